// File: rtl/audio_clk_enable_gen_pkg.sv
// Shared types and helpers for the audio clock-enable generator.
// Imported by the interface, channel and top.
package audio_clk_pkg;

   typedef enum logic [1:0] {
      UNLOCKED,
      QUALIFY,
      RUN
   } state_t;

   localparam int DIV_W_DEF = 12;

   // Never returns 0 so that single-entry selects keep a 1-bit port.
   function automatic int clog2_safe(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/audio_clk_enable_gen_if.sv
// Divisor configuration handshake.
// The generator is the slave; cfg_ready never applies backpressure.
interface audio_clk_enable_gen_if
   import audio_clk_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int DIV_W  = DIV_W_DEF
);
   logic                            cfg_valid;
   logic                            cfg_ready;
   logic [clog2_safe(NUM_CH)-1:0]   cfg_ch;
   logic [DIV_W-1:0]                cfg_div;

   modport master (
      output cfg_valid,
      output cfg_ch,
      output cfg_div,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_ch,
      input  cfg_div,
      output cfg_ready
   );
endinterface

// File: rtl/audio_clk_enable_gen_channel.sv
// One enable channel: wrap counter, active and pending divisor.
// New divisors are only taken at a wrap, while idle, or while disabled.
module audio_clk_en_channel
   import audio_clk_pkg::*;
#(
   parameter int DIV_W       = DIV_W_DEF,
   parameter int DEFAULT_DIV = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             restart,
   input  logic             wr,
   input  logic [DIV_W-1:0] wr_div,
   output logic             en
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div;
   logic [DIV_W-1:0] pending;
   logic             pend;
   logic             wrap;
   logic             load;
   logic [DIV_W-1:0] nxt;

   always_comb begin
      wrap = (div != '0) && (cnt == div - DIV_W'(1));
      load = !run || restart || (div == '0) || wrap;
      nxt  = wr ? wr_div : (pend ? pending : div);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         div     <= DIV_W'(DEFAULT_DIV);
         pending <= DIV_W'(DEFAULT_DIV);
         pend    <= 1'b0;
         en      <= 1'b0;
      end else begin
         en <= run && wrap;
         if (load) begin
            cnt     <= '0;
            div     <= nxt;
            pending <= nxt;
            pend    <= 1'b0;
         end else begin
            cnt <= cnt + DIV_W'(1);
            if (wr) begin
               pending <= wr_div;
               pend    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/audio_clk_enable_gen.sv
// Lock-qualified multi-channel clock-enable generator.
// Synchroniser, lock FSM, loss counter and the channel array.
module audio_clk_enable_gen
   import audio_clk_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int DIV_W       = DIV_W_DEF,
   parameter int DEFAULT_DIV = 8,
   parameter int LOCK_STABLE = 1024,
   parameter int LOSS_CNT_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  locked,
   audio_clk_enable_gen_if.slave cfg,
   output logic [NUM_CH-1:0]     en,
   output logic                  clk_ok,
   output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

   localparam int QW = clog2_safe(LOCK_STABLE + 1);

   logic          sync1;
   logic          locked_sync;
   state_t        state;
   logic [QW-1:0] qual_cnt;
   logic          qual_done;
   logic          run;
   logic          restart;
   logic          accept;

   always_comb begin
      qual_done = (qual_cnt == QW'(LOCK_STABLE - 1));
      run       = (state == RUN) && locked_sync;
      restart   = (state == QUALIFY) && locked_sync && qual_done;
      accept    = cfg.cfg_valid && cfg.cfg_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1         <= 1'b0;
         locked_sync   <= 1'b0;
         state         <= UNLOCKED;
         qual_cnt      <= '0;
         clk_ok        <= 1'b0;
         lock_loss_cnt <= '0;
         cfg.cfg_ready <= 1'b0;
      end else begin
         sync1         <= locked;
         locked_sync   <= sync1;
         cfg.cfg_ready <= 1'b1;
         unique case (state)
            UNLOCKED: begin
               if (locked_sync) begin
                  state    <= QUALIFY;
                  qual_cnt <= '0;
               end
            end
            QUALIFY: begin
               if (!locked_sync) begin
                  state <= UNLOCKED;
               end else if (qual_done) begin
                  state  <= RUN;
                  clk_ok <= 1'b1;
               end else begin
                  qual_cnt <= qual_cnt + QW'(1);
               end
            end
            RUN: begin
               if (!locked_sync) begin
                  state  <= UNLOCKED;
                  clk_ok <= 1'b0;
                  if (lock_loss_cnt != '1)
                     lock_loss_cnt <= lock_loss_cnt + LOSS_CNT_W'(1);
               end
            end
            default: begin
               state  <= UNLOCKED;
               clk_ok <= 1'b0;
            end
         endcase
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      audio_clk_en_channel #(
         .DIV_W       (DIV_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .run     (run),
         .restart (restart),
         .wr      (accept && (32'(cfg.cfg_ch) == i)),
         .wr_div  (cfg.cfg_div),
         .en      (en[i])
      );
   end

endmodule

// File: tb/tb_audio_clk_enable_gen.sv
// Directed bench for audio_clk_enable_gen with LOCK_STABLE=16.
// Expected latencies and periods are hand-derived constants.
module tb_audio_clk_enable_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       locked;
   logic [3:0] en;
   logic       clk_ok;
   logic [7:0] lock_loss_cnt;

   int vectors     = 0;
   int miscompares = 0;

   audio_clk_enable_gen_if #(.NUM_CH(4), .DIV_W(12)) cfg_if ();

   audio_clk_enable_gen #(
      .NUM_CH      (4),
      .DIV_W       (12),
      .DEFAULT_DIV (8),
      .LOCK_STABLE (16),
      .LOSS_CNT_W  (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .locked        (locked),
      .cfg           (cfg_if),
      .en            (en),
      .clk_ok        (clk_ok),
      .lock_loss_cnt (lock_loss_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wr_cfg(input int ch, input int dv);
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_ch    = 2'(ch);
      cfg_if.cfg_div   = 12'(dv);
      tick();
      cfg_if.cfg_valid = 1'b0;
   endtask

   task automatic wait_en(input int ch, input int lim, output int n);
      n = -1;
      for (int i = 1; i <= lim; i++) begin
         tick();
         if (en[ch]) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic wait_ok(input int lim, output int n);
      n = -1;
      for (int i = 1; i <= lim; i++) begin
         tick();
         if (clk_ok) begin
            n = i;
            break;
         end
      end
   endtask

   initial begin
      int n;
      int cnt;
      int bad;
      rst              = 1'b1;
      locked           = 1'b0;
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_ch    = '0;
      cfg_if.cfg_div   = '0;
      repeat (3) tick();
      chk("rst_en", 32'(en), 0);
      chk("rst_clk_ok", 32'(clk_ok), 0);
      chk("rst_loss", 32'(lock_loss_cnt), 0);
      chk("rst_ready", 32'(cfg_if.cfg_ready), 0);

      rst    = 1'b0;
      locked = 1'b1;
      wait_ok(100, n);
      chk("lock_to_run", n, 19);
      chk("ready_up", 32'(cfg_if.cfg_ready), 1);
      wait_en(0, 40, n);
      chk("en0_first", n, 8);
      chk("phase_align", 32'(en), 32'hF);
      wait_en(0, 40, n);
      chk("en0_period_a", n, 8);
      wait_en(0, 40, n);
      chk("en0_period_b", n, 8);

      tick();
      tick();
      wr_cfg(1, 3);
      wait_en(1, 20, n);
      chk("ch1_mid_old", n, 5);
      wait_en(1, 20, n);
      chk("ch1_mid_new_a", n, 3);
      wait_en(1, 20, n);
      chk("ch1_mid_new_b", n, 3);

      tick();
      tick();
      wr_cfg(1, 6);
      chk("ch1_wrap_pulse", 32'(en[1]), 1);
      wait_en(1, 20, n);
      chk("ch1_wrap_new_a", n, 6);
      wait_en(1, 20, n);
      chk("ch1_wrap_new_b", n, 6);

      wait_en(2, 20, n);
      wr_cfg(2, 0);
      repeat (8) tick();
      cnt = 0;
      repeat (30) begin
         tick();
         if (en[2]) cnt++;
      end
      chk("ch2_disabled", cnt, 0);
      wr_cfg(2, 5);
      wait_en(2, 20, n);
      chk("ch2_reenable", n, 5);
      wait_en(2, 20, n);
      chk("ch2_period", n, 5);

      wait_en(0, 20, n);
      repeat (5) tick();
      locked = 1'b0;
      tick();
      tick();
      chk("ok_before_fall", 32'(clk_ok), 1);
      tick();
      chk("drop_en", 32'(en), 0);
      chk("drop_clk_ok", 32'(clk_ok), 0);
      chk("drop_loss", 32'(lock_loss_cnt), 1);
      bad = 0;
      for (int i = 0; i < 299; i++) begin
         locked = 1'b1;
         wait_ok(100, n);
         if (n != 19) bad++;
         locked = 1'b0;
         repeat (4) tick();
      end
      chk("requal_loop", bad, 0);
      chk("loss_sat", 32'(lock_loss_cnt), 255);

      locked = 1'b1;
      wait_ok(100, n);
      chk("requal", n, 19);
      wr_cfg(0, 5);
      wait_en(0, 20, n);
      wait_en(0, 20, n);
      chk("ch0_div5_a", n, 5);
      wait_en(0, 20, n);
      chk("ch0_div5_b", n, 5);
      rst = 1'b1;
      tick();
      chk("mid_rst_en", 32'(en), 0);
      chk("mid_rst_ok", 32'(clk_ok), 0);
      chk("mid_rst_loss", 32'(lock_loss_cnt), 0);
      chk("mid_rst_ready", 32'(cfg_if.cfg_ready), 0);
      rst = 1'b0;
      wait_ok(100, n);
      chk("post_rst_run", n, 19);
      wait_en(0, 40, n);
      chk("post_rst_first", n, 8);
      wait_en(0, 40, n);
      chk("post_rst_period", n, 8);

      rst    = 1'b1;
      locked = 1'b0;
      repeat (3) tick();
      rst    = 1'b0;
      locked = 1'b1;
      cnt    = 0;
      repeat (10) begin
         tick();
         if (clk_ok) cnt++;
      end
      locked = 1'b0;
      repeat (40) begin
         tick();
         if (clk_ok) cnt++;
      end
      chk("short_lock_ok", cnt, 0);
      chk("short_lock_loss", 32'(lock_loss_cnt), 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
